// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the fault-slave FSM state type.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_ERR1,
        FS_ERR2
    } fault_slave_state_t;

endpackage

// File: rtl/ahb3lite_sat_cnt.sv
// Saturating up-counter; a clear coinciding with an increment yields 1.
module ahb3lite_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc) begin
            if (clr)                 r_cnt <= W'(1);
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + W'(1);
        end else if (clr) begin
            r_cnt <= '0;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/ahb3lite_fault_slave.sv
// AHB3-Lite default/fault slave: answers every transfer with optional wait
// states and an ERROR (or OKAY) response, and logs the offending transfer.
module ahb3lite_fault_slave
    import ahb3lite_pkg::*;
#(
    parameter int          WAIT_STATES = 0,
    parameter int          ERR_MODE    = 1,
    parameter logic [31:0] RDATA_VAL   = 32'hDEADBEEF,
    parameter int          CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic             HWRITE,
    input  logic [1:0]       HTRANS,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic [31:0]      HRDATA,
    output logic [31:0]      FAULT_ADDR,
    output logic             FAULT_WRITE,
    output logic [CNT_W-1:0] FAULT_CNT,
    output logic             FAULT_IRQ,
    input  logic             FAULT_CLR
);

    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam bit         ERR_EN    = (ERR_MODE != 0);
    localparam logic [3:0] WCNT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    fault_slave_state_t r_state, w_state_nxt;
    logic [3:0]         r_wcnt, w_wcnt_nxt;
    logic               w_accept;
    logic [31:0]        r_hrdata;
    logic [31:0]        r_faddr;
    logic               r_fwrite;
    logic               r_irq;

    assign w_accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= FS_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Accepts only matter in IDLE/ERR2; elsewhere HREADY is low on a legal bus.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        case (r_state)
            FS_IDLE, FS_ERR2: begin
                HRESP       = (r_state == FS_ERR2);
                w_state_nxt = FS_IDLE;
                if (w_accept) begin
                    if (HAS_WAIT) begin
                        w_state_nxt = FS_WAIT;
                        w_wcnt_nxt  = WCNT_LOAD;
                    end else if (ERR_EN) begin
                        w_state_nxt = FS_ERR1;
                    end
                end
            end
            FS_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_wcnt == 4'd0) w_state_nxt = ERR_EN ? FS_ERR1 : FS_IDLE;
                else                w_wcnt_nxt  = r_wcnt - 4'd1;
            end
            FS_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = FS_ERR2;
            end
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_hrdata <= '0;
            r_faddr  <= '0;
            r_fwrite <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_hrdata <= RDATA_VAL;
            if (w_accept) begin
                r_faddr  <= HADDR;
                r_fwrite <= HWRITE;
                r_irq    <= 1'b1;
            end else if (FAULT_CLR) begin
                r_irq    <= 1'b0;
            end
        end
    end

    ahb3lite_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk   (CLK),
        .rst_n (RESETn),
        .inc   (w_accept),
        .clr   (FAULT_CLR),
        .cnt   (FAULT_CNT)
    );

    assign HRDATA      = r_hrdata;
    assign FAULT_ADDR  = r_faddr;
    assign FAULT_WRITE = r_fwrite;
    assign FAULT_IRQ   = r_irq;

endmodule

// File: tb/tb_ahb3lite_fault_slave.sv
// Four fault-slave configurations driven side by side and checked against a
// timing model based on cycles elapsed since each instance's last accept.
module tb_ahb3lite_fault_slave;

    localparam int N = 4;
    localparam logic [31:0] RDV = 32'hDEADBEEF;
    // per instance: wait states, error mode, counter max
    int WS_A [N] = '{0, 3, 2, 0};
    int EM_A [N] = '{1, 1, 0, 1};
    int CMAX [N] = '{255, 255, 255, 3};

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        hsel [N], hwrite [N], hready [N], fclr [N];
    logic [1:0]  htrans [N];
    logic [31:0] haddr [N];
    logic        hro [N], hresp [N], fwr [N], firq [N];
    logic [31:0] hrdata [N], faddr [N];
    logic [7:0]  fcnt8 [3];
    logic [1:0]  fcnt3;

    always #5 CLK = ~CLK;

    ahb3lite_fault_slave u_d0 (.CLK(CLK), .RESETn(RESETn), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HWRITE(hwrite[0]), .HTRANS(htrans[0]), .HREADY(hready[0]), .HREADYOUT(hro[0]),
        .HRESP(hresp[0]), .HRDATA(hrdata[0]), .FAULT_ADDR(faddr[0]), .FAULT_WRITE(fwr[0]),
        .FAULT_CNT(fcnt8[0]), .FAULT_IRQ(firq[0]), .FAULT_CLR(fclr[0]));
    ahb3lite_fault_slave #(.WAIT_STATES(3), .ERR_MODE(1)) u_d1 (.CLK(CLK), .RESETn(RESETn),
        .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]), .HTRANS(htrans[1]),
        .HREADY(hready[1]), .HREADYOUT(hro[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]),
        .FAULT_ADDR(faddr[1]), .FAULT_WRITE(fwr[1]), .FAULT_CNT(fcnt8[1]), .FAULT_IRQ(firq[1]),
        .FAULT_CLR(fclr[1]));
    ahb3lite_fault_slave #(.WAIT_STATES(2), .ERR_MODE(0)) u_d2 (.CLK(CLK), .RESETn(RESETn),
        .HSEL(hsel[2]), .HADDR(haddr[2]), .HWRITE(hwrite[2]), .HTRANS(htrans[2]),
        .HREADY(hready[2]), .HREADYOUT(hro[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]),
        .FAULT_ADDR(faddr[2]), .FAULT_WRITE(fwr[2]), .FAULT_CNT(fcnt8[2]), .FAULT_IRQ(firq[2]),
        .FAULT_CLR(fclr[2]));
    ahb3lite_fault_slave #(.CNT_W(2)) u_d3 (.CLK(CLK), .RESETn(RESETn), .HSEL(hsel[3]),
        .HADDR(haddr[3]), .HWRITE(hwrite[3]), .HTRANS(htrans[3]), .HREADY(hready[3]),
        .HREADYOUT(hro[3]), .HRESP(hresp[3]), .HRDATA(hrdata[3]), .FAULT_ADDR(faddr[3]),
        .FAULT_WRITE(fwr[3]), .FAULT_CNT(fcnt3), .FAULT_IRQ(firq[3]), .FAULT_CLR(fclr[3]));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          cyc = 0;
    int          t_acc [N];
    logic [31:0] m_addr [N];
    logic        m_wr [N], m_irq [N], m_ok [N];
    int          m_cnt [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int i);
        case (i)
            0: return int'(fcnt8[0]);
            1: return int'(fcnt8[1]);
            2: return int'(fcnt8[2]);
            default: return int'(fcnt3);
        endcase
    endfunction

    // {HREADYOUT, HRESP} expected k cycles after an accept
    function automatic logic [1:0] exp_resp(input int i);
        int k = cyc - t_acc[i];
        if (k >= 1 && k <= WS_A[i]) return 2'b00;
        if (EM_A[i] != 0) begin
            if (k == WS_A[i] + 1) return 2'b01;
            if (k == WS_A[i] + 2) return 2'b11;
        end
        return 2'b10;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            t_acc[i] = -100; m_addr[i] = '0; m_wr[i] = 1'b0;
            m_cnt[i] = 0;    m_irq[i] = 1'b0; m_ok[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        cyc++;
        if (RESETn) begin
            for (int i = 0; i < N; i++) begin
                m_ok[i] = 1'b1;
                if (hsel[i] && hready[i] && htrans[i][1]) begin
                    t_acc[i]  = cyc - 1;
                    m_addr[i] = haddr[i];
                    m_wr[i]   = hwrite[i];
                    m_irq[i]  = 1'b1;
                    m_cnt[i]  = fclr[i] ? 1 : ((m_cnt[i] < CMAX[i]) ? m_cnt[i] + 1 : m_cnt[i]);
                end else if (fclr[i]) begin
                    m_cnt[i] = 0;
                    m_irq[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [1:0] e;
        for (int i = 0; i < N; i++) begin
            e = exp_resp(i);
            chk($sformatf("hreadyout%0d", i), 32'(hro[i]), 32'(e[1]));
            chk($sformatf("hresp%0d", i), 32'(hresp[i]), 32'(e[0]));
            chk($sformatf("hrdata%0d", i), hrdata[i], m_ok[i] ? RDV : 32'h0);
            chk($sformatf("faddr%0d", i), faddr[i], m_addr[i]);
            chk($sformatf("fwrite%0d", i), 32'(fwr[i]), 32'(m_wr[i]));
            chk($sformatf("fcnt%0d", i), 32'(cnt_of(i)), 32'(m_cnt[i]));
            chk($sformatf("firq%0d", i), 32'(firq[i]), 32'(m_irq[i]));
        end
    endtask

    task automatic set_idle();
        logic [1:0] e;
        for (int i = 0; i < N; i++) begin
            e = exp_resp(i);
            hready[i] = e[1];
            hsel[i] = 1'b0; htrans[i] = 2'b00; fclr[i] = 1'b0;
            hwrite[i] = 1'b0; haddr[i] = '0;
        end
    endtask

    // one clock: model follows the edge, outputs checked on the falling edge
    task automatic step();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        check_all();
        set_idle();
    endtask

    task automatic put(input int i, input logic [31:0] a, input logic w);
        hsel[i] = 1'b1; htrans[i] = 2'b10; haddr[i] = a; hwrite[i] = w;
    endtask

    logic [1:0] obs [N][6];
    logic [1:0] tab [N][6] = '{'{2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10},
                               '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10},
                               '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10},
                               '{2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10}};

    initial begin
        int n;
        RESETn = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            hready[i] = 1'b1; hsel[i] = 1'b0; htrans[i] = 2'b00;
            fclr[i] = 1'b0; hwrite[i] = 1'b0; haddr[i] = '0;
        end
        #1 RESETn = 1'b0;
        @(negedge CLK);
        check_all();
        RESETn = 1'b1;
        step();

        // single transfer on every configuration; instance 2 writes
        for (int i = 0; i < N; i++) put(i, 32'h4000_0010, i == 2);
        for (int s = 0; s < 6; s++) begin
            step();
            for (int i = 0; i < N; i++) obs[i][s] = {hro[i], hresp[i]};
        end
        for (int i = 0; i < N; i++)
            for (int s = 0; s < 6; s++)
                chk($sformatf("seq%0d_%0d", i, s), 32'(obs[i][s]), 32'(tab[i][s]));
        chk("d_faddr", faddr[0], 32'h4000_0010);
        chk("d_fcnt", 32'(fcnt8[0]), 32'd1);
        chk("d_firq", 32'(firq[0]), 32'd1);
        chk("okay_fwrite", 32'(fwr[2]), 32'd1);

        // clear alone, then back-to-back NONSEQ during ERR2
        fclr[0] = 1'b1;
        step();
        chk("clr_cnt", 32'(fcnt8[0]), 32'd0);
        chk("clr_irq", 32'(firq[0]), 32'd0);
        put(0, 32'h1000_0004, 1'b0);
        step();
        step();
        chk("b2b_err2", 32'({hro[0], hresp[0]}), 32'(2'b11));
        put(0, 32'h2000_0008, 1'b1);
        step();
        chk("b2b_err1", 32'({hro[0], hresp[0]}), 32'(2'b01));
        chk("b2b_addr", faddr[0], 32'h2000_0008);
        chk("b2b_cnt", 32'(fcnt8[0]), 32'd2);
        step(); step();

        // saturation on the 2-bit counter, then clear racing a new accept
        fclr[3] = 1'b1;
        step();
        n = 0;
        for (int c = 0; c < 50 && n < 5; c++) begin
            if (hready[3]) begin put(3, 32'h3000_0000 + 32'(n), 1'b0); n++; end
            step();
        end
        chk("sat_accepts", 32'(n), 32'd5);
        chk("sat_cnt", 32'(fcnt3), 32'd3);
        for (int c = 0; c < 10 && !hready[3]; c++) step();
        put(3, 32'h3000_00F0, 1'b1);
        fclr[3] = 1'b1;
        step();
        chk("clrinc_cnt", 32'(fcnt3), 32'd1);
        chk("clrinc_irq", 32'(firq[3]), 32'd1);
        for (int c = 0; c < 6; c++) step();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hready[i]) hready[i] = ($urandom_range(0, 7) != 0);
                hsel[i]   = $urandom_range(0, 3) != 0;
                htrans[i] = 2'($urandom_range(0, 3));
                haddr[i]  = $urandom;
                hwrite[i] = $urandom_range(0, 1) != 0;
                fclr[i]   = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        for (int c = 0; c < 20; c++) step();

        // reset asserted during ERR1
        put(0, 32'h5000_0000, 1'b1);
        step();
        chk("pre_rst_err1", 32'({hro[0], hresp[0]}), 32'(2'b01));
        RESETn = 1'b0;
        model_reset();
        #1;
        chk("rst_hro", 32'(hro[0]), 32'd1);
        chk("rst_hresp", 32'(hresp[0]), 32'd0);
        chk("rst_hrdata", hrdata[0], 32'h0);
        chk("rst_faddr", faddr[0], 32'h0);
        chk("rst_fcnt", 32'(fcnt8[0]), 32'd0);
        chk("rst_firq", 32'(firq[0]), 32'd0);
        check_all();
        @(negedge CLK);
        RESETn = 1'b1;
        set_idle();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                hsel[i] = 1'b1;
                htrans[i] = 2'($urandom_range(0, 1));
            end
            step();
            chk("post_rst_hro", 32'(hro[0]), 32'd1);
            chk("post_rst_hresp", 32'(hresp[0]), 32'd0);
            chk("post_rst_cnt", 32'(fcnt8[0]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
